// File: rtl/sub16_serial.sv
// sub16_serial: bit-serial subtractor computing a - b as a + ~b + 1.
// One full-adder step per RUN cycle, LSB first. The result and flags are
// held in DONE until the consumer takes them.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its data while valid is high and ready is low.
// in_ready is high only in IDLE with reset released. out_valid is high only
// in DONE, and the result is held stable there until out_ready is seen.
module sub16_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zr,
  output logic             ng,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] sh_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic             borrow_q, zr_q, ng_q, ovf_q;

  logic             bit_a, bit_nb;
  logic             sum_d, carry_d;
  logic [WIDTH-1:0] sh_d;

  // One full-adder step on the current bit. The sum enters the shift register at the MSB.
  always_comb begin
    bit_a   = a_q[cnt_q];
    bit_nb  = ~b_q[cnt_q];
    sum_d   = bit_a ^ bit_nb ^ carry_q;
    carry_d = (bit_a & bit_nb) | (bit_a & carry_q) | (bit_nb & carry_q);
    sh_d    = WIDTH'({sum_d, sh_q} >> 1);
  end

  // Control FSM and datapath registers. Flags are latched on the last RUN step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sh_q        <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      borrow_q    <= 1'b0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            sh_q    <= '0;
            carry_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sh_q    <= sh_d;
          carry_q <= carry_d;
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            borrow_q    <= ~carry_d;
            zr_q        <= (sh_d == '0);
            ng_q        <= sh_d[WIDTH-1];
            ovf_q       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                           (sh_d[WIDTH-1] != a_q[WIDTH-1]);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            borrow_q    <= 1'b0;
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
            ovf_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready is gated by rst_n so that it reads 0 for the whole time reset is held.
  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = sh_q;
  assign borrow    = borrow_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sub16_serial.sv
// Testbench for sub16_serial: table of hand-computed subtraction vectors plus
// directed sequences for backpressure, mid-RUN reset and back-to-back ops.
module tb_sub16_serial;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow, zr, ng, ovf;
  logic [1:0]   dbg_state;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zr;
    logic         ng;
    logic         ovf;
  } vec_t;

  vec_t vecs[10];
  logic [W-1:0] exp_q[$];

  sub16_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .zr(zr), .ng(ng), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge right after an accept edge. Counts edges until out_valid.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, n, 16);
  endtask

  task automatic chk_result(input string name, input vec_t v);
    chk({name, " out_valid"}, {31'b0, out_valid}, 1);
    chk({name, " diff"}, {16'b0, diff}, {16'b0, v.diff});
    chk({name, " flags"}, {28'b0, borrow, zr, ng, ovf}, {28'b0, v.borrow, v.zr, v.ng, v.ovf});
  endtask

  // Drives one op from IDLE; a/b are scrambled during RUN to show they are not sampled.
  task automatic run_op(input string name, input vec_t v);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, " in_ready"}, {31'b0, in_ready}, 1);
    in_valid = 1'b1;
    a = v.a;
    b = v.b;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom_range(0, 65535));
    b = W'($urandom_range(0, 65535));
    wait_done(name);
    chk_result(name, v);
  endtask

  initial begin
    vec_t v;
    int acc[3];
    int seen;

    vecs[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h0010, 16'h0020, 16'hFFF0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{16'hABCD, 16'h1234, 16'h9999, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{16'h0001, 16'hFFFF, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", {31'b0, in_ready}, 0);
    chk("reset out_valid", {31'b0, out_valid}, 0);
    chk("reset diff", {16'b0, diff}, 0);
    chk("reset flags", {28'b0, borrow, zr, ng, ovf}, 0);
    chk("reset state", {30'b0, dbg_state}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", {31'b0, in_ready}, 1);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d idle flags", i), {27'b0, out_valid, borrow, zr, ng, ovf}, 0);
    end

    // Backpressure: hold DONE for 5 cycles, operands wiggled in RUN
    out_ready = 1'b0;
    run_op("bp", vecs[0]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d", k), {16'b0, diff}, 16'h0002);
      chk($sformatf("bp hold%0d ctl", k), {26'b0, out_valid, in_ready, borrow, zr, ng, ovf}, 6'b100000);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release", {30'b0, out_valid, in_ready}, 2'b01);

    // Reset mid-RUN aborts the op
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst in_ready low", {30'b0, in_ready, out_valid}, 0);
    rst_n = 1'b1;
    #1;
    chk("midrst in_ready", {31'b0, in_ready}, 1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst no out_valid", seen, 0);
    run_op("midrst newop", vecs[4]);
    @(negedge clk);

    // Back-to-back with in_valid held high
    for (int k = 0; k < 3; k++) exp_q.push_back(vecs[k+1].diff);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      seen = 0;
      while (!in_ready && seen < 40) begin
        @(negedge clk);
        seen++;
      end
      chk($sformatf("b2b%0d ready", k), {31'b0, in_ready}, 1);
      acc[k] = cyc;
      a = vecs[k+1].a;
      b = vecs[k+1].b;
      @(negedge clk);
      wait_done($sformatf("b2b%0d", k));
      v = vecs[k+1];
      chk_result($sformatf("b2b%0d", k), v);
      if (exp_q.size() > 0) chk($sformatf("b2b%0d queue", k), {16'b0, diff}, {16'b0, exp_q.pop_front()});
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b gap01", acc[1] - acc[0], 18);
    chk("b2b gap12", acc[2] - acc[1], 18);
    repeat (2) @(negedge clk);
    chk("b2b final idle", {30'b0, in_ready, out_valid}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sub16_serial.md
SUB16_SERIAL -- requirements
Module: sub16_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operands a, b presented.
REQ-005 SHALL have port in_ready  output  1  block idle, can accept operands.
REQ-006 SHALL have port a  input  WIDTH  minuend.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port out_valid  output  1  result and flags valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-011 SHALL have port borrow  output  1  1 when unsigned a < b.
REQ-012 SHALL have port zr  output  1  1 when diff == 0.
REQ-013 SHALL have port ng  output  1  diff[WIDTH-1].
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow of a - b.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-016 SHALL accept operands on the edge where in_valid && in_ready; a and b are registered then, and later changes on a/b are ignored until the next accept.
REQ-017 SHALL compute a + ~b + 1 bit-serially, LSB first, one full-adder step per RUN cycle, carry register initialised to 1 on accept.
REQ-018 SHALL spend exactly WIDTH cycles in RUN; bit counter wraps from WIDTH-1 to DONE, no extra cycle.
REQ-019 Latency: accept on edge T -> out_valid high after edge T+WIDTH (T+16 at default).
REQ-020 borrow SHALL equal the inverted final carry out of bit WIDTH-1.
REQ-021 ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using registered operands.
REQ-022 zr, ng, ovf, borrow, diff SHALL be stable and registered throughout DONE.
REQ-023 In DONE, outputs SHALL hold unchanged while out_ready = 0, for any number of cycles.
REQ-024 On edge where out_valid && out_ready, SHALL go to IDLE; in_ready rises the next cycle (no same-cycle re-accept; one bubble cycle per op).
REQ-025 in_valid asserted during RUN or DONE SHALL be ignored, no operand capture.
REQ-026 diff SHALL not be required to be meaningful outside DONE; flags SHALL be 0 outside DONE.

Reset
REQ-027 With rst_n = 0 at an edge, SHALL enter IDLE, clear operand, shift, carry and counter registers; diff = 0, borrow = zr = ng = ovf = 0, out_valid = 0.
REQ-028 in_ready SHALL be 0 while rst_n = 0 and 1 in the first cycle after rst_n returns to 1.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort the operation; no partial result or out_valid produced afterwards.

Verification
REQ-030 a=0x0005, b=0x0003 -> after 16 cycles diff=0x0002, borrow=0, zr=0, ng=0, ovf=0.
REQ-031 a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, ng=1, ovf=0, zr=0.
REQ-032 a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, borrow=0, ng=0; a=0x1234, b=0x1234 -> diff=0x0000, zr=1, borrow=0.
REQ-033 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs constant, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle; a/b toggled during RUN do not alter result.
REQ-034 Reset: rst_n=0 for one edge at RUN cycle 8 of a=0xFFFF, b=0x0001 -> out_valid stays 0, in_ready=1 next cycle, new op a=0x0010, b=0x0020 -> diff=0xFFF0, borrow=1, ng=1.
REQ-035 Back-to-back: in_valid held 1 for three ops -> each accepted exactly once, 18 cycles apart with out_ready=1 (16 RUN + DONE + IDLE).
